reg_write_arbiter: RTL



---
 rtl/reg_write_arbiter_pkg.sv | 23 ++
 rtl/reg_write_arbiter_if.sv | 34 +++
 rtl/reg_write_arbiter_rr_picker.sv | 35 +++
 rtl/reg_write_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared state encoding and default sizing for the register write arbiter.
// The locked-burst default only exists when ARB_LOCK_EN is defined.
package reg_write_arbiter_pkg;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_DATA_W = 7;
`ifdef ARB_LOCK_EN
    localparam int DEF_MAX_BURST = 4;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester/register bundle of the write arbiter; ARB_LOCK_EN adds the lock vector.
interface reg_write_arbiter_if
    import reg_write_arbiter_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DATA_W = DEF_DATA_W
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic                    clr_req;
`ifdef ARB_LOCK_EN
    logic [N_REQ-1:0]        lock;
`endif
    logic [N_REQ-1:0]        ack;
    logic                    clr_ack;
    logic [N_REQ-1:0]        grant;
    logic                    busy;
    logic                    reg_enable;
    logic [DATA_W-1:0]       reg_d;
    logic                    reg_clear;

`ifdef ARB_LOCK_EN
    modport master (output req, wdata, clr_req, lock,
                    input  ack, clr_ack, grant, busy, reg_enable, reg_d, reg_clear);
    modport slave  (input  req, wdata, clr_req, lock,
                    output ack, clr_ack, grant, busy, reg_enable, reg_d, reg_clear);
`else
    modport master (output req, wdata, clr_req,
                    input  ack, clr_ack, grant, busy, reg_enable, reg_d, reg_clear);
    modport slave  (input  req, wdata, clr_req,
                    output ack, clr_ack, grant, busy, reg_enable, reg_d, reg_clear);
`endif

endinterface

// File: rtl/reg_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request above rr_ptr, wrapping at N_REQ-1.
module reg_write_arbiter_rr_picker #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [PTR_W-1:0] win_idx,
    output logic             any_req
);

    // Scan N_REQ positions starting just after the last winner.
    always_comb begin
        logic [PTR_W-1:0] pos;
        logic             found;
        pos     = '0;
        found   = 1'b0;
        win_oh  = '0;
        win_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            pos = PTR_W'((int'(rr_ptr) + k) % N_REQ);
            if (!found && req[pos]) begin
                found        = 1'b1;
                win_idx      = pos;
                win_oh[pos]  = 1'b1;
            end else begin
                found = found;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write/clear sequencer in front of one shared clear/enable register.
// Define ARB_LOCK_EN to add per-requester locked bursts of up to MAX_BURST writes.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DATA_W = DEF_DATA_W
`ifdef ARB_LOCK_EN
    ,parameter int MAX_BURST = DEF_MAX_BURST
`endif
) (
    input  logic                clock,
    input  logic                reset_n,
    reg_write_arbiter_if.slave  bus
);

    localparam int PTR_W = ptr_width(N_REQ);

    arb_state_e        state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0]  win_idx_q, win_idx_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] reg_d_q, reg_d_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              clr_ack_q, clr_ack_d;
    logic              busy_q, busy_d;
    logic              reg_enable_q, reg_enable_d;
    logic              reg_clear_q, reg_clear_d;

    logic [N_REQ-1:0]  pick_oh_s;
    logic [PTR_W-1:0]  pick_idx_s;
    logic              any_req_s;
    logic              lock_cont_s;

    function automatic logic [DATA_W-1:0] data_slice(input logic [N_REQ*DATA_W-1:0] packed_data,
                                                     input logic [PTR_W-1:0]        sel);
        logic [DATA_W-1:0] res;
        res = '0;
        for (int i = 0; i < N_REQ; i++) begin
            res = res | (packed_data[i*DATA_W +: DATA_W] & {DATA_W{sel == PTR_W'(i)}});
        end
        return res;
    endfunction

    reg_write_arbiter_rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req     (bus.req),
        .rr_ptr  (rr_ptr_q),
        .win_oh  (pick_oh_s),
        .win_idx (pick_idx_s),
        .any_req (any_req_s)
    );

`ifdef ARB_LOCK_EN
    localparam int BC_W = $clog2(MAX_BURST) + 1;
    logic [BC_W-1:0] burst_cnt_q, burst_cnt_d;

    // A burst continues only while the owner still locks and requests, and no clear waits.
    assign lock_cont_s = bus.lock[win_idx_q] & bus.req[win_idx_q] & ~bus.clr_req
                       & (burst_cnt_q < BC_W'(MAX_BURST - 1));
`else
    assign lock_cont_s = 1'b0;
`endif

    // Next-state, data latch and registered-output decode.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        win_idx_d = win_idx_q;
        rr_ptr_d  = rr_ptr_q;
        reg_d_d   = reg_d_q;
`ifdef ARB_LOCK_EN
        burst_cnt_d = burst_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.clr_req) begin
                    state_d = ST_CLEAR;
                end else if (any_req_s) begin
                    state_d   = ST_WRITE;
                    grant_d   = pick_oh_s;
                    win_idx_d = pick_idx_s;
                    reg_d_d   = data_slice(bus.wdata, pick_idx_s);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: state_d = ST_DONE;
            ST_CLEAR: state_d = ST_DONE;
            ST_DONE: begin
                // A non-zero grant here means the finishing operation was a write.
                if (|grant_q) begin
                    rr_ptr_d = win_idx_q;
                end else begin
                    rr_ptr_d = rr_ptr_q;
                end
                if ((|grant_q) && lock_cont_s) begin
                    state_d = ST_WRITE;
                    reg_d_d = data_slice(bus.wdata, win_idx_q);
`ifdef ARB_LOCK_EN
                    burst_cnt_d = burst_cnt_q + BC_W'(1);
`endif
                end else begin
                    state_d = ST_IDLE;
                    grant_d = '0;
`ifdef ARB_LOCK_EN
                    burst_cnt_d = '0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        reg_enable_d = (state_d == ST_WRITE);
        reg_clear_d  = (state_d == ST_CLEAR);
        busy_d       = (state_d != ST_IDLE);
        ack_d        = (state_q == ST_WRITE) ? grant_q : '0;
        clr_ack_d    = (state_q == ST_CLEAR);
    end

    // State and output registers; reset drops every register pin at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            win_idx_q    <= '0;
            rr_ptr_q     <= PTR_W'(N_REQ - 1);
            reg_d_q      <= '0;
            ack_q        <= '0;
            clr_ack_q    <= 1'b0;
            busy_q       <= 1'b0;
            reg_enable_q <= 1'b0;
            reg_clear_q  <= 1'b0;
`ifdef ARB_LOCK_EN
            burst_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            win_idx_q    <= win_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            reg_d_q      <= reg_d_d;
            ack_q        <= ack_d;
            clr_ack_q    <= clr_ack_d;
            busy_q       <= busy_d;
            reg_enable_q <= reg_enable_d;
            reg_clear_q  <= reg_clear_d;
`ifdef ARB_LOCK_EN
            burst_cnt_q  <= burst_cnt_d;
`endif
        end
    end

    assign bus.ack        = ack_q;
    assign bus.clr_ack    = clr_ack_q;
    assign bus.grant      = grant_q;
    assign bus.busy       = busy_q;
    assign bus.reg_enable = reg_enable_q;
    assign bus.reg_d      = reg_d_q;
    assign bus.reg_clear  = reg_clear_q;

endmodule
